// File: rtl/exposure_timer_pkg.sv
// Camera timing definitions shared by the exposure timer and the exposure-control FSM:
// exposure limits, clock ratios and the timer state codes.
package exposure_timer_pkg;

    localparam int CAM_CLK_PER_MS  = 1000;
    localparam int CAM_EXP_MIN     = 2;
    localparam int CAM_EXP_MAX     = 30;
    localparam int CAM_EXP_DEFAULT = 15;
    localparam int CAM_READ_CYCLES = 4;
    localparam int EXP_W           = 5;

    typedef enum logic {
        TIMER_IDLE   = 1'b0,
        TIMER_EXPOSE = 1'b1
    } timer_state_t;

    // Saturating step of the exposure setting; simultaneous inc and dec cancel out.
    function automatic logic [EXP_W-1:0] next_exp_setting(
        input logic [EXP_W-1:0] cur,
        input logic             inc_edge,
        input logic             dec_edge,
        input logic [EXP_W-1:0] lo,
        input logic [EXP_W-1:0] hi
    );
        logic [EXP_W-1:0] nxt;
        nxt = cur;
        if (inc_edge && !dec_edge && cur < hi)
            nxt = cur + 1'b1;
        else if (dec_edge && !inc_edge && cur > lo)
            nxt = cur - 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/exposure_timer_ms.sv
// Millisecond prescaler: a one-cycle tick every CLK_PER_MS clocks while clear is low.
module ms_tick_gen #(
    parameter int CLK_PER_MS = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

    logic [W-1:0] pre_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            pre_cnt <= '0;
        else if (clear || pre_cnt == LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = ~clear & (pre_cnt == LAST);

endmodule

// File: rtl/exposure_timer.sv
// Exposure countdown, user exposure setting and readout-slot counter feeding the
// exposure-control FSM (Ovf5 = exposure done, Ovf4 = readout slot done).
module exposure_timer
    import exposure_timer_pkg::*;
#(
    parameter int CLK_PER_MS  = CAM_CLK_PER_MS,
    parameter int EXP_MIN     = CAM_EXP_MIN,
    parameter int EXP_MAX     = CAM_EXP_MAX,
    parameter int EXP_DEFAULT = CAM_EXP_DEFAULT,
    parameter int READ_CYCLES = CAM_READ_CYCLES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start_Timer,
    input  logic       Readout_En,
    input  logic       Exp_Inc,
    input  logic       Exp_Dec,
    output logic       Ovf5,
    output logic       Ovf4,
    output logic       Busy,
    output logic [4:0] Exp_Time
);

    localparam int RD_W = $clog2(READ_CYCLES);
    localparam logic [RD_W-1:0]  RD_LAST   = RD_W'(READ_CYCLES - 1);
    localparam logic [EXP_W-1:0] EXP_LO    = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] EXP_HI    = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_RESET = EXP_W'(EXP_DEFAULT);

    timer_state_t     state_q, state_d;
    logic [EXP_W-1:0] ms_cnt;
    logic [EXP_W-1:0] exp_time_q;
    logic [RD_W-1:0]  rd_cnt;
    logic             ms_tick;
    logic             load_cnt;
    logic             dec_cnt;
    logic             ovf5_d;
    logic             inc_prev, dec_prev;
    logic             inc_edge, dec_edge;

    // The prescaler is held clear in IDLE so every exposure starts on a fresh millisecond.
    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_ms_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (state_q == TIMER_IDLE),
        .tick  (ms_tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state_q <= TIMER_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        ovf5_d   = 1'b0;
        case (state_q)
            TIMER_IDLE: begin
                if (Start_Timer) begin
                    state_d  = TIMER_EXPOSE;
                    load_cnt = 1'b1;
                end
            end
            TIMER_EXPOSE: begin
                if (ms_tick) begin
                    if (ms_cnt <= 5'd1) begin
                        state_d = TIMER_IDLE;
                        ovf5_d  = 1'b1;
                    end
                    dec_cnt = (ms_cnt != '0);
                end
            end
            default: state_d = TIMER_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ms_cnt <= '0;
            Ovf5   <= 1'b0;
        end else begin
            Ovf5 <= ovf5_d;
            if (load_cnt)
                ms_cnt <= exp_time_q;
            else if (dec_cnt)
                ms_cnt <= ms_cnt - 1'b1;
        end
    end

    assign inc_edge = Exp_Inc & ~inc_prev;
    assign dec_edge = Exp_Dec & ~dec_prev;

    // Edge registers track the buttons continuously, so a press during EXPOSE is simply lost.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            inc_prev   <= 1'b0;
            dec_prev   <= 1'b0;
            exp_time_q <= EXP_RESET;
        end else begin
            inc_prev <= Exp_Inc;
            dec_prev <= Exp_Dec;
            if (state_q == TIMER_IDLE && !Start_Timer)
                exp_time_q <= next_exp_setting(exp_time_q, inc_edge, dec_edge, EXP_LO, EXP_HI);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_cnt <= '0;
            Ovf4   <= 1'b0;
        end else if (!Readout_En) begin
            rd_cnt <= '0;
            Ovf4   <= 1'b0;
        end else begin
            Ovf4   <= (rd_cnt == RD_LAST);
            rd_cnt <= (rd_cnt == RD_LAST) ? '0 : rd_cnt + 1'b1;
        end
    end

    assign Busy     = (state_q == TIMER_EXPOSE);
    assign Exp_Time = exp_time_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer with CLK_PER_MS=4 and READ_CYCLES=4.
module tb_exposure_timer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start_Timer = 1'b0;
    logic       Readout_En = 1'b0;
    logic       Exp_Inc = 1'b0;
    logic       Exp_Dec = 1'b0;
    logic       Ovf5, Ovf4, Busy;
    logic [4:0] Exp_Time;

    int checks = 0;
    int errors = 0;
    int exp_model;

    exposure_timer #(
        .CLK_PER_MS  (4),
        .EXP_MIN     (2),
        .EXP_MAX     (30),
        .EXP_DEFAULT (15),
        .READ_CYCLES (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start_Timer (Start_Timer),
        .Readout_En  (Readout_En),
        .Exp_Inc     (Exp_Inc),
        .Exp_Dec     (Exp_Dec),
        .Ovf5        (Ovf5),
        .Ovf4        (Ovf4),
        .Busy        (Busy),
        .Exp_Time    (Exp_Time)
    );

    always #5 Clk = ~Clk;

    // Drive inputs for the next rising edge, then return 1 time unit after it.
    task automatic applyStimulus(input logic start, input logic rd, input logic inc, input logic dec);
        Start_Timer = start;
        Readout_En  = rd;
        Exp_Inc     = inc;
        Exp_Dec     = dec;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        // Reset values
        applyStimulus(0, 0, 0, 0);
        checkOutput("reset_ovf5", Ovf5, 0);
        checkOutput("reset_ovf4", Ovf4, 0);
        checkOutput("reset_busy", Busy, 0);
        checkOutput("reset_exp", Exp_Time, 15);
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0);

        // 15 ms exposure: Ovf5 exactly 60 edges after the start sample edge
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_busy_start", Busy, 1);
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("t1_ovf5_k%0d", k), Ovf5, (k == 60) ? 1 : 0);
            checkOutput($sformatf("t1_busy_k%0d", k), Busy, (k < 60) ? 1 : 0);
        end

        // Exposure setting saturation
        doReset();
        exp_model = 15;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 1, 0);
            exp_model = (exp_model < 30) ? exp_model + 1 : 30;
            checkOutput($sformatf("t2_inc_%0d", i), Exp_Time, exp_model);
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("t2_inc_sat", Exp_Time, 30);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0, 1);
            exp_model = (exp_model > 2) ? exp_model - 1 : 2;
            checkOutput($sformatf("t2_dec_%0d", i), Exp_Time, exp_model);
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("t2_dec_sat", Exp_Time, 2);
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_hold_inc", Exp_Time, 3);

        // 2 ms exposure with an inc press and a second start mid-exposure
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_exp2", Exp_Time, 2);
        applyStimulus(1, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            applyStimulus((k == 5), 0, (k == 3), 0);
            checkOutput($sformatf("t3_ovf5_k%0d", k), Ovf5, (k == 8) ? 1 : 0);
            checkOutput($sformatf("t3_busy_k%0d", k), Busy, (k < 8) ? 1 : 0);
        end
        checkOutput("t3_exp_frozen", Exp_Time, 2);

        // Readout slots, including a drop at rd_cnt=2
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("t4_ovf4_k%0d", k), Ovf4, (k == 4 || k == 8) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_idle_ovf4", Ovf4, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_drop_ovf4", Ovf4, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("t4_reraise_k%0d", k), Ovf4, (k == 4) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0);

        // Asynchronous reset in the middle of an exposure
        doReset();
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_exp16", Exp_Time, 16);
        applyStimulus(1, 0, 0, 0);
        for (int k = 1; k <= 30; k++)
            applyStimulus(0, 0, 0, 0);
        checkOutput("t5_busy_before", Busy, 1);
        Reset = 1'b1;
        #1;
        checkOutput("t5_rst_busy", Busy, 0);
        checkOutput("t5_rst_ovf5", Ovf5, 0);
        checkOutput("t5_rst_exp", Exp_Time, 15);
        applyStimulus(0, 0, 0, 0);
        Reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("t5_no_ovf5_k%0d", k), Ovf5, 0);
        end
        checkOutput("t5_busy_after", Busy, 0);

        // Simultaneous buttons, then exposure and readout together
        applyStimulus(0, 0, 1, 1);
        checkOutput("t6_both_edges", Exp_Time, 15);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("t6_ovf5_k%0d", k), Ovf5, (k == 60) ? 1 : 0);
            checkOutput($sformatf("t6_ovf4_k%0d", k), Ovf4, ((k % 4) == 3) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
